// File: rtl/jtcop_obj_dma_pkg.sv
// Shared definitions for the object-RAM DMA sequencer: address width,
// sequencer states and the registered buffer-write payload.
package jtcop_obj_dma_pkg;

    localparam int unsigned OBJ_AW = 10;
    localparam int unsigned OBJ_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COPY  = 2'd1,
        ST_FLUSH = 2'd2
    } dma_state_t;

    // One buffer write: valid flag plus the address of the word read a cycle earlier
    typedef struct packed {
        logic              we;
        logic [OBJ_AW-1:0] addr;
    } buf_wr_t;

    // CPU byte enables, active only while the CPU selects object RAM
    function automatic logic [1:0] cpu_byte_we(input logic cs, input logic udswn, input logic ldswn);
        return cs ? ~{udswn, ldswn} : 2'b00;
    endfunction

endpackage

// File: rtl/jtcop_obj_dma_if.sv
// CPU bus, object RAM port and line-buffer source write port seen by the DMA.
interface jtcop_obj_dma_if;
    import jtcop_obj_dma_pkg::*;

    logic                obj_copy;
    logic                obj_cs;
    logic [OBJ_AW-1:0]   cpu_addr;
    logic [OBJ_DW-1:0]   cpu_dout;
    logic                UDSWn;
    logic                LDSWn;

    logic [OBJ_AW-1:0]   ram_addr;
    logic [1:0]          ram_we;
    logic [OBJ_DW-1:0]   ram_din;
    logic [OBJ_DW-1:0]   ram_dout;

    logic [OBJ_AW-1:0]   buf_addr;
    logic [OBJ_DW-1:0]   buf_din;
    logic                buf_we;

    modport master (
        input  obj_copy, obj_cs, cpu_addr, cpu_dout, UDSWn, LDSWn, ram_dout,
        output ram_addr, ram_we, ram_din, buf_addr, buf_din, buf_we
    );

    modport slave (
        output obj_copy, obj_cs, cpu_addr, cpu_dout, UDSWn, LDSWn, ram_dout,
        input  ram_addr, ram_we, ram_din, buf_addr, buf_din, buf_we
    );

endinterface

// File: rtl/jtcop_obj_dma.sv
// Object RAM to line-buffer source copy during vertical blank, sharing the
// object RAM port with the main CPU (CPU always wins the port).
module jtcop_obj_dma
    import jtcop_obj_dma_pkg::*;
(
    input  logic            rst,
    input  logic            clk,
    input  logic            LVBL,
    jtcop_obj_dma_if.master bus,
    output logic            dma_busy
);

    localparam int unsigned AW = OBJ_AW;

    dma_state_t     st;
    logic [AW-1:0]  rd_cnt;
    buf_wr_t        wr;
    logic           copy_l;
    logic           pend;

    logic           copy_edge;
    logic           dma_rd;
    logic           rd_last;
    logic           start;
    logic           pend_nx;
    logic           busy_nx;

    assign copy_edge = bus.obj_copy & ~copy_l;
    assign dma_rd    = (st == ST_COPY) & ~bus.obj_cs;
    assign rd_last   = &rd_cnt;
    assign start     = (st == ST_IDLE) & pend & ~LVBL;
    // An edge landing on the start cycle re-arms the request for a second copy
    assign pend_nx   = (pend & ~start) | copy_edge;
    // Next state is COPY or FLUSH exactly when starting or currently copying
    assign busy_nx   = pend_nx | start | (st == ST_COPY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            rd_cnt   <= '0;
            wr       <= '0;
            copy_l   <= 1'b0;
            pend     <= 1'b0;
            dma_busy <= 1'b0;
        end else begin
            copy_l   <= bus.obj_copy;
            pend     <= pend_nx;
            dma_busy <= busy_nx;
            wr.we    <= dma_rd;
            if (dma_rd) wr.addr <= rd_cnt;
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        rd_cnt <= '0;
                        st     <= ST_COPY;
                    end
                end
                ST_COPY: begin
                    // Counter parks on the last address instead of wrapping
                    if (dma_rd) begin
                        if (rd_last) st <= ST_FLUSH;
                        else         rd_cnt <= rd_cnt + AW'(1);
                    end
                end
                ST_FLUSH: st <= ST_IDLE;
                default:  st <= ST_IDLE;
            endcase
        end
    end

    // RAM port is combinational so CPU accesses see no added latency
    assign bus.ram_addr = dma_rd ? rd_cnt : bus.cpu_addr;
    assign bus.ram_we   = cpu_byte_we(bus.obj_cs, bus.UDSWn, bus.LDSWn);
    assign bus.ram_din  = bus.cpu_dout;

    // RAM output is already registered; it lines up with the delayed write flag
    assign bus.buf_addr = wr.addr;
    assign bus.buf_we   = wr.we;
    assign bus.buf_din  = bus.ram_dout;

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Directed bench for jtcop_obj_dma with behavioural object RAM and buffer.
module tb_jtcop_obj_dma;

    logic clk = 1'b0;
    logic rst;
    logic LVBL;
    logic dma_busy;

    jtcop_obj_dma_if bus();

    jtcop_obj_dma dut (
        .rst      (rst),
        .clk      (clk),
        .LVBL     (LVBL),
        .bus      (bus.master),
        .dma_busy (dma_busy)
    );

    always #5 clk = ~clk;

    logic [15:0] mem  [1024];
    logic [15:0] bufm [1024];
    int          wcnt [1024];
    int          we_cnt;
    logic        clr;

    // Registered-read object RAM with byte writes; buffer with write statistics
    always @(posedge clk) begin
        bus.ram_dout <= mem[bus.ram_addr];
        if (bus.ram_we[1]) mem[bus.ram_addr][15:8] <= bus.ram_din[15:8];
        if (bus.ram_we[0]) mem[bus.ram_addr][7:0]  <= bus.ram_din[7:0];
        if (clr) begin
            we_cnt <= 0;
            for (int i = 0; i < 1024; i++) begin
                wcnt[i] <= 0;
                bufm[i] <= 16'h0000;
            end
        end else if (bus.buf_we) begin
            we_cnt              <= we_cnt + 1;
            wcnt[bus.buf_addr]  <= wcnt[bus.buf_addr] + 1;
            bufm[bus.buf_addr]  <= bus.buf_din;
        end
    end

    int checks = 0;
    int errors = 0;
    int k;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_stats();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [15:0] d);
        bus.obj_cs   = 1'b1;
        bus.cpu_addr = a;
        bus.cpu_dout = d;
        bus.UDSWn    = 1'b0;
        bus.LDSWn    = 1'b0;
        @(negedge clk);
        bus.obj_cs   = 1'b0;
        bus.UDSWn    = 1'b1;
        bus.LDSWn    = 1'b1;
    endtask

    task automatic check_buf(input string tag, input int rep, input logic ff_top);
        int bad_d;
        int bad_c;
        logic [15:0] e;
        bad_d = 0;
        bad_c = 0;
        for (int i = 0; i < 1024; i++) begin
            e = 16'(i) ^ 16'h5A5A;
            if (ff_top && i == 1023) e = 16'hFFFF;
            if (bufm[i] !== e) bad_d++;
            if (wcnt[i] != rep) bad_c++;
        end
        check({tag, "_data_bad"}, 32'(bad_d), 32'd0);
        check({tag, "_wcnt_bad"}, 32'(bad_c), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        LVBL         = 1'b1;
        clr          = 1'b0;
        bus.obj_copy = 1'b0;
        bus.obj_cs   = 1'b0;
        bus.cpu_addr = 10'h000;
        bus.cpu_dout = 16'h0000;
        bus.UDSWn    = 1'b1;
        bus.LDSWn    = 1'b1;
        step(3);

        // Reset state
        check("rst_busy",     32'(dma_busy),     32'd0);
        check("rst_buf_we",   32'(bus.buf_we),   32'd0);
        check("rst_buf_addr", 32'(bus.buf_addr), 32'd0);
        check("rst_ram_we",   32'(bus.ram_we),   32'd0);
        rst = 1'b0;
        step(2);

        // CPU pass-through while idle
        bus.cpu_addr = 10'h1A5;
        bus.cpu_dout = 16'hBEEF;
        bus.obj_cs   = 1'b1;
        bus.UDSWn    = 1'b0;
        bus.LDSWn    = 1'b1;
        #1;
        check("idle_ram_addr", 32'(bus.ram_addr), 32'h1A5);
        check("idle_ram_we",   32'(bus.ram_we),   32'h2);
        check("idle_ram_din",  32'(bus.ram_din),  32'hBEEF);
        bus.obj_cs = 1'b0;
        #1;
        check("idle_ram_we_nocs", 32'(bus.ram_we), 32'h0);
        bus.UDSWn = 1'b1;
        step(1);

        for (int i = 0; i < 1024; i++) cpu_write(10'(i), 16'(i) ^ 16'h5A5A);
        clear_stats();

        // Basic copy in blank, with first-word timing
        LVBL         = 1'b0;
        bus.cpu_addr = 10'h2AA;
        bus.obj_copy = 1'b1;
        k = 0;
        step(1); k = 1;
        check("basic_busy_k1",     32'(dma_busy),     32'd1);
        check("basic_addr_k1",     32'(bus.ram_addr), 32'h2AA);
        step(1); k = 2;
        check("basic_addr_k2",     32'(bus.ram_addr), 32'h000);
        step(1); k = 3;
        bus.obj_copy = 1'b0;
        check("basic_we_k3",       32'(bus.buf_we),   32'd1);
        check("basic_baddr_k3",    32'(bus.buf_addr), 32'h000);
        check("basic_bdin_k3",     32'(bus.buf_din),  32'h5A5A);
        while (dma_busy && k < 3000) begin
            step(1); k++;
        end
        check("basic_done_cycle",  32'(k),      32'd1027);
        check("basic_we_count",    32'(we_cnt), 32'd1024);
        check_buf("basic", 1, 1'b0);

        // Request outside blank waits for LVBL low; copy completes after leaving blank
        clear_stats();
        LVBL = 1'b1;
        bus.obj_copy = 1'b1;
        step(2);
        bus.obj_copy = 1'b0;
        step(50);
        check("wait_busy",     32'(dma_busy), 32'd1);
        check("wait_no_we",    32'(we_cnt),   32'd0);
        bus.cpu_addr = 10'h155;
        LVBL = 1'b0;
        step(1);
        check("wait_start_addr", 32'(bus.ram_addr), 32'h000);
        LVBL = 1'b1;
        step(1);
        check("wait_first_we",   32'(bus.buf_we),   32'd1);
        k = 0;
        while (dma_busy && k < 2000) begin
            step(1); k++;
        end
        check("wait_done_cycle", 32'(k),      32'd1024);
        check("wait_we_count",   32'(we_cnt), 32'd1024);
        check_buf("wait", 1, 1'b0);

        // CPU stalls every third copy cycle, writing FFFF to the last address
        clear_stats();
        LVBL = 1'b0;
        bus.obj_copy = 1'b1;
        k = 0;
        do begin
            step(1); k++;
            if (k == 3) bus.obj_copy = 1'b0;
            if (k >= 2 && ((k - 2) % 3) == 2) begin
                bus.obj_cs   = 1'b1;
                bus.cpu_addr = 10'h3FF;
                bus.cpu_dout = 16'hFFFF;
                bus.UDSWn    = 1'b0;
                bus.LDSWn    = 1'b0;
            end else begin
                bus.obj_cs   = 1'b0;
                bus.UDSWn    = 1'b1;
                bus.LDSWn    = 1'b1;
            end
            if (k == 4) begin
                #1;
                check("ilv_cpu_addr", 32'(bus.ram_addr), 32'h3FF);
                check("ilv_cpu_we",   32'(bus.ram_we),   32'h3);
            end
        end while (dma_busy && k < 4000);
        bus.obj_cs = 1'b0;
        bus.UDSWn  = 1'b1;
        bus.LDSWn  = 1'b1;
        // 511 stall cycles land before the final DMA read
        check("ilv_done_cycle", 32'(k),      32'd1538);
        check("ilv_we_count",   32'(we_cnt), 32'd1024);
        check_buf("ilv", 1, 1'b1);
        cpu_write(10'h3FF, 16'h3FF ^ 16'h5A5A);

        // Three requests: second re-arms during copy, third merges
        clear_stats();
        LVBL = 1'b0;
        bus.obj_copy = 1'b1;
        k = 0;
        do begin
            step(1); k++;
            if (k == 3 || k == 103 || k == 203) bus.obj_copy = 1'b0;
            if (k == 100 || k == 200)           bus.obj_copy = 1'b1;
        end while (dma_busy && k < 5000);
        check("rep_done_cycle", 32'(k),      32'd2053);
        check("rep_we_count",   32'(we_cnt), 32'd2048);
        check_buf("rep", 2, 1'b0);

        // Reset at word 500 aborts the copy and drops a pending request
        clear_stats();
        bus.cpu_addr = 10'h0F0;
        bus.obj_copy = 1'b1;
        k = 0;
        while (!(bus.buf_we === 1'b1 && bus.buf_addr === 10'd500) && k < 2000) begin
            step(1); k++;
            if (k == 3 || k == 103) bus.obj_copy = 1'b0;
            if (k == 100)           bus.obj_copy = 1'b1;
        end
        check("rst_reach_500", 32'(bus.buf_addr), 32'd500);
        rst = 1'b1;
        #1;
        check("rst_mid_we",      32'(bus.buf_we),   32'd0);
        check("rst_mid_busy",    32'(dma_busy),     32'd0);
        check("rst_mid_baddr",   32'(bus.buf_addr), 32'd0);
        check("rst_mid_ram_we",  32'(bus.ram_we),   32'd0);
        check("rst_mid_ramaddr", 32'(bus.ram_addr), 32'h0F0);
        step(1);
        rst = 1'b0;
        step(100);
        check("rst_after_count", 32'(we_cnt),   32'd500);
        check("rst_after_busy",  32'(dma_busy), 32'd0);

        // Fresh request after reset runs a full copy
        clear_stats();
        bus.obj_copy = 1'b1;
        step(2);
        bus.obj_copy = 1'b0;
        k = 0;
        while (dma_busy && k < 2000) begin
            step(1); k++;
        end
        check("post_rst_we_count", 32'(we_cnt), 32'd1024);
        check_buf("post_rst", 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtcop_obj_dma.md
# jtcop_obj_dma

Object-RAM DMA sequencer and port arbiter for the main CPU bus. A CPU write strobe on `obj_copy` requests a copy of the 1024-word object RAM into the object line-buffer source RAM (the *DM function). The copy runs during vertical blank. The block shares the object RAM port between CPU accesses (`obj_cs`) and the DMA reader, giving the CPU priority. It sits between the main-CPU decoder and the object RAM/buffer memories.

## Interface
- `AW`, 10: word-address width of object RAM and buffer (1024 words).
- `rst` in 1: asynchronous reset, active high.
- `clk` in 1: system clock; all logic runs on this one clock.
- `LVBL` in 1: vertical blank, active low.
- `obj_copy` in 1: decoded CPU write strobe; level, held for the whole bus cycle.
- `obj_cs` in 1: CPU object-RAM chip select.
- `cpu_addr` in AW: CPU word address `A[AW:1]`.
- `cpu_dout` in 16: CPU write data.
- `UDSWn`, `LDSWn` in 1 each: CPU byte write strobes, active low.
- `ram_addr` out AW: object RAM address.
- `ram_we` out 2: object RAM byte write enables, `{upper, lower}`.
- `ram_din` out 16: object RAM write data.
- `ram_dout` in 16: object RAM read data; registered, 1-cycle latency.
- `buf_addr` out AW: buffer write address.
- `buf_din` out 16: buffer write data.
- `buf_we` out 1: buffer word write enable.
- `dma_busy` out 1: high from request acceptance until the last buffer write.

## Operation
- **Request capture.** A rising edge of `obj_copy` sets `pend`. Further edges while `pend` is already set are merged into it.
- **IDLE.** If `pend` is set and `LVBL` is 0, clear `pend`, clear `rd_cnt`, and go to COPY. If `pend` is set and `LVBL` is 1, stay in IDLE.
- **COPY.** Each cycle with `obj_cs` low, the DMA owns the port:
  - `ram_addr = rd_cnt`, `ram_we = 0`.
  - `rd_cnt` increments.
  - Set `vld` for the next cycle and record `wr_addr <= rd_cnt`.
- **CPU priority.** When `obj_cs` is high, the CPU owns the port:
  - `ram_addr = cpu_addr`.
  - `ram_we = ~{UDSWn, LDSWn}`.
  - `ram_din = cpu_dout`.
  - The DMA holds `rd_cnt` and clears `vld` for the next cycle.
- **Buffer write.** Every cycle with `vld` set: `buf_we = 1`, `buf_addr = wr_addr`, `buf_din = ram_dout`. The read was issued on the previous cycle, so CPU use of the port in the current cycle does not corrupt it.
- **Completion.** After the read at `rd_cnt = 2^AW-1` is issued, go to FLUSH. FLUSH performs the final buffer write, then returns to IDLE.
- **dma_busy.** High when `pend` is set, or the state is COPY or FLUSH.
- **Request during a copy.** An edge of `obj_copy` during COPY sets `pend`. A second full copy follows immediately if still in blank, otherwise at the next blank.
- **Leaving blank mid-copy.** A copy already in COPY runs to completion even if `LVBL` returns high.
- **Outside COPY.** `ram_addr` follows `cpu_addr` at all times. `ram_we` follows the CPU strobes qualified by `obj_cs`.
- **Counter width.** `rd_cnt` is AW bits with a separate terminal flag; it never wraps during a copy.

## Timing
- **Reset values.** State IDLE, `pend = 0`, `vld = 0`, `rd_cnt = 0`, `wr_addr = 0`, `buf_we = 0`, `dma_busy = 0`. `ram_we = 0` while `obj_cs` is low.
- **Request to start.** The `obj_copy` edge sets `pend` on the next clock. COPY is entered on the following clock if `LVBL` is 0.
- **Duration.** An unstalled copy takes 2^AW + 1 cycles from COPY entry to IDLE. Each CPU stall cycle adds one cycle.
- **Per-word latency.** The buffer write follows its RAM read by exactly 1 cycle.
- **Registered outputs.** `buf_*` and `dma_busy` are registered.
- **Combinational outputs.** `ram_addr`, `ram_we`, `ram_din` are combinational from state and CPU inputs, so the CPU sees zero added latency.
- **Reset mid-copy.** Aborts immediately. No further buffer writes; the pending request is lost.

## Structure
- Define `OBJ_AW` and the state encoding (IDLE, COPY, FLUSH) in the shared `jtcop_pkg`.
- Build it as a single module; no sub-module is required.
- The parent connects `obj_copy` and `obj_cs` from the main-CPU decoder.

## Test plan
- **Basic copy.** Fill RAM with `word[i] = i ^ 16'h5A5A`; pulse `obj_copy` with `LVBL = 0` → exactly 1024 `buf_we` pulses, `buf[i] = i ^ 16'h5A5A`, `dma_busy` low 1027 cycles after the edge.
- **Wait for blank.** Request with `LVBL = 1` → no `buf_we` and `dma_busy = 1` until `LVBL` falls, then the copy starts 1 cycle later.
- **CPU interleave.** Assert `obj_cs` every third cycle during a copy, writing `16'hFFFF` to address 0x3FF before the DMA reaches it → the buffer holds `16'hFFFF` at 0x3FF, no address is skipped or duplicated, and the copy is stretched by the number of stall cycles.
- **Repeated request.** Two `obj_copy` edges 100 cycles apart in blank → two full copies back to back; the third edge merges into a pending request.
- **Reset mid-copy.** Assert `rst` at word 500 → `buf_we` drops the same cycle, every output is at its reset value, and there is no activity until a new request.
